// File: rtl/mult_booth.sv
// Radix-2 Booth signed 32x32 multiplier, one iteration per clock.
// Reports the low 32 product bits plus a signed-overflow flag.
module mult_booth (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [32:0] acc_q, acc_d;
  logic [32:0] m_q, m_d;
  logic [31:0] q_q, q_d;
  logic        q1_q, q1_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
    end
  end

  // 33-bit add/sub keeps -(-2^31) representable without wrap.
  always_comb begin
    sum = acc_q;
    case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    if (ctrl_MULT) begin
      state_d = BUSY;
      acc_d   = '0;
      m_d     = {data_operandA[31], data_operandA};
      q_d     = data_operandB;
      q1_d    = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BUSY: begin
          acc_d = {sum[32], sum[32:1]};
          q_d   = {sum[0], q_q[31:1]};
          q1_d  = q_q[0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Product is {ACC[31:0], Q}; it fits in 32 bits only if the top half is all sign.
  assign data_result    = q_q;
  assign data_exception = (acc_q[31:0] != {32{q_q[31]}});
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == BUSY);

endmodule

// File: tb/tb_mult_booth.sv
// Randomized self-checking bench for mult_booth against a plain
// 64-bit signed multiply reference.
module tb_mult_booth;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mult_booth dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($signed($urandom_range(0, 200)) - 100);
      default: return $urandom;
    endcase
  endfunction

  // Drive a start at the current negedge; return at the negedge after the load edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    launch(a, b);
  endtask

  // Count edges until the ready pulse; scramble operands to show they are ignored.
  task automatic wait_done(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int lat;
    lat = 0;
    p = ref_prod(a, b);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
      data_operandA = $urandom;
      data_operandB = $urandom;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd32);
    chk({tag, ".result"}, 64'(data_result), 64'(p[31:0]));
    chk({tag, ".exception"}, 64'(data_exception), 64'(p[63:32] != {32{p[31]}}));
    chk({tag, ".busy_done"}, 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    start(a, b);
    wait_done(tag, a, b);
    @(negedge clock);
    chk({tag, ".rdy_one_cycle"}, 64'(data_resultRDY), 64'd0);
    chk({tag, ".hold"}, 64'(data_result), 64'(ref_prod(a, b) >> 0) & 64'hFFFF_FFFF);
  endtask

  initial begin
    logic [31:0] a, b;
    int pulses;

    // Start request coincident with reset must be ignored.
    ctrl_MULT = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.result", 64'(data_result), 64'd0);
    chk("reset.exception", 64'(data_exception), 64'd0);
    chk("reset.rdy", 64'(data_resultRDY), 64'd0);
    chk("reset.busy", 64'(busy), 64'd0);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    chk("reset.ctrl_ignored", 64'(busy), 64'd0);

    run_op("small", 32'd3, 32'd4);
    run_op("neg", 32'hFFFF_FFFB, 32'd7);
    run_op("minint", 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("ovf16", 32'h0001_0000, 32'h0001_0000);
    run_op("maxint", 32'h7FFF_FFFF, 32'h7FFF_FFFF);

    // Reset mid-operation: outputs clear and no late pulse.
    start(32'd2, 32'd2);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst.result", 64'(data_result), 64'd0);
    chk("midrst.busy", 64'(busy), 64'd0);
    chk("midrst.exception", 64'(data_exception), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("midrst.no_pulse", 64'(pulses), 64'd0);

    // Restart while busy: only the second operation reports.
    start(32'd2, 32'd2);
    repeat (10) @(negedge clock);
    launch(32'd6, 32'hFFFF_FFFF);
    wait_done("restart", 32'd6, 32'hFFFF_FFFF);

    // Back-to-back: load during the DONE cycle.
    launch(32'd9, 32'hFFFF_FFF0);
    wait_done("b2b", 32'd9, 32'hFFFF_FFF0);

    // Start held for three edges: last operands win, latency from last edge.
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd100; data_operandB = 32'd100;
    @(negedge clock);
    data_operandA = 32'd7;   data_operandB = 32'd11;
    @(negedge clock);
    launch(32'hFFFF_FFFD, 32'd1000);
    wait_done("held", 32'hFFFF_FFFD, 32'd1000);

    for (int i = 0; i < 40; i++) begin
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d", i), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 Port: clock  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 Port: ctrl_MULT  input  1  start pulse, sampled on the rising edge of clock.
REQ-005 Port: data_operandA  input  32  multiplicand, two's complement; sampled only when ctrl_MULT=1.
REQ-006 Port: data_operandB  input  32  multiplier, two's complement; sampled only when ctrl_MULT=1.
REQ-007 Port: data_result  output  32  low 32 bits of the signed product.
REQ-008 Port: data_exception  output  1  signed overflow: the product does not fit in 32 bits.
REQ-009 Port: data_resultRDY  output  1  one-cycle pulse marking data_result and data_exception as valid.
REQ-010 Port: busy  output  1  high while an operation is in progress.

Function
REQ-011 The block SHALL implement radix-2 Booth multiplication over 32 iterations, with one iteration per clock cycle.
REQ-012 The block SHALL use three states:
- IDLE: no operation.
- BUSY: iterating.
- DONE: a single cycle, during which data_resultRDY=1.
REQ-013 State register contents:
- 33-bit accumulator ACC, sign-extended.
- 32-bit register Q.
- 1-bit Q_1.
- 33-bit multiplicand register M, equal to sign-extended operand A.
- 6-bit iteration counter CNT.
REQ-014 Load: on an edge with ctrl_MULT=1 in any state, the block SHALL set:
- ACC=0, Q=operandB, Q_1=0, M=sext(operandA), CNT=0;
- state to BUSY.
REQ-015 Iteration step (each BUSY edge), depending on {Q[0],Q_1}:
- 01 -> ACC=ACC+M;
- 10 -> ACC=ACC-M;
- 00 or 11 -> ACC unchanged.
Then {ACC,Q,Q_1} SHALL be arithmetically shifted right by 1, with the sign bit ACC[32] replicated, and CNT incremented.
REQ-016 All ACC arithmetic SHALL be 33-bit; the 33-bit width prevents intermediate overflow when operandA = 0x80000000.
REQ-017 On the BUSY edge where CNT reaches 32, the state SHALL move to DONE.
REQ-018 On the DONE edge, the state SHALL move to IDLE unless ctrl_MULT=1; if ctrl_MULT=1, REQ-014 applies.
REQ-019 Latency: with ctrl_MULT sampled at edge N, data_resultRDY SHALL be 1 exactly in the cycle after edge N+32, and for that one cycle only.
REQ-020 data_result SHALL be Q once 32 iterations are complete, and SHALL hold that value until the next load or reset.
REQ-021 data_exception SHALL be 1 iff ACC[31:0] is not all copies of Q[31]; it SHALL hold with data_result.
REQ-022 busy SHALL be 1 in BUSY and 0 in IDLE and DONE.
REQ-023 Restart: if ctrl_MULT=1 while BUSY, the block SHALL abort the current operation and reload per REQ-014; no data_resultRDY pulse is produced for the aborted operation.
REQ-024 Operand changes while BUSY with ctrl_MULT=0 SHALL have no effect.
REQ-025 ctrl_MULT held high for k cycles SHALL restart the operation at each of those edges; the result corresponds to the last sampled operands.

Reset
REQ-026 On reset=1 the block SHALL asynchronously set:
- state=IDLE, ACC=0, Q=0, Q_1=0, M=0, CNT=0.
- data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-027 Reset asserted mid-operation SHALL discard that operation; no data_resultRDY pulse follows after reset is released.
REQ-028 A ctrl_MULT coincident with reset SHALL be ignored; a start pulse SHALL only be accepted on the first rising edge with reset=0.

Verification
REQ-029 A=3, B=4, start at edge N -> data_resultRDY=1 only in the cycle after edge N+32; result=0x0000000C; exception=0.
REQ-030 A=-5, B=7 -> result=0xFFFFFFDD; exception=0.
REQ-031 A=0x80000000, B=0xFFFFFFFF -> result=0x80000000; exception=1.
REQ-032 A=0x00010000, B=0x00010000 -> result=0x00000000; exception=1.
REQ-033 A=0x7FFFFFFF, B=0x7FFFFFFF, with operands changed while busy -> result=0x00000001; exception=1.
REQ-034 Start A=2, B=2, then at iteration 10:
- either assert reset -> all outputs 0 and no data_resultRDY pulse;
- or restart with A=6, B=-1 -> a single data_resultRDY pulse 32 cycles after the restart edge, with result=0xFFFFFFFA and exception=0.
